// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds, synchronous flush and error pulses.
module fifo_sync_param #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     W_EN,
    input  logic [WIDTH-1:0]         W_DI,
    input  logic                     REN,
    output logic [WIDTH-1:0]         R_DO,
    output logic                     R_VALID,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     AFULL,
    output logic                     AEMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UDF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_ok, rd_ok;

    assign FULL   = (count_q == FULL_C);
    assign EMPTY  = (count_q == '0);
    assign AFULL  = (count_q >= AFULL_C);
    assign AEMPTY = (count_q <= AEMPTY_C);
    assign COUNT  = count_q;
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

    assign wr_ok = W_EN & ~FULL & ~CLR;
    assign rd_ok = REN & ~EMPTY & ~CLR;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = W_EN & FULL & ~CLR;
        udf_d   = REN & EMPTY & ~CLR;
        if (CLR) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + 1'b1;
            if (rd_ok) rptr_d = rptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage has no reset; gating with RST keeps a write coinciding with reset out of the array.
    always_ff @(posedge CLK) begin
        if (wr_ok && !RST) mem_q[wptr_q] <= W_DI;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign R_DO    = EMPTY ? '0 : mem_q[rptr_q];
            assign R_VALID = ~EMPTY;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) rdata_q <= mem_q[rptr_q];
                end
            end

            assign R_DO    = rdata_q;
            assign R_VALID = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-mode and an FWFT-mode FIFO (DEPTH=4) with identical stimulus
// and compares both against a queue-based reference model every cycle.
module tb_fifo_sync_param;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int S_AF  = 3;
    localparam int S_AE  = 1;
    localparam int F_AF  = DEPTH - 2;
    localparam int F_AE  = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CLR = 1'b0;
    logic             W_EN = 1'b0;
    logic [WIDTH-1:0] W_DI = '0;
    logic             REN = 1'b0;

    logic [WIDTH-1:0] s_rdo, f_rdo;
    logic             s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic             f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [2:0]       s_cnt, f_cnt;

    fifo_sync_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AFULL_TH(S_AF), .AEMPTY_TH(S_AE)) u_std (
        .CLK(CLK), .RST(RST), .CLR(CLR), .W_EN(W_EN), .W_DI(W_DI), .REN(REN),
        .R_DO(s_rdo), .R_VALID(s_rv), .FULL(s_full), .EMPTY(s_empty),
        .AFULL(s_af), .AEMPTY(s_ae), .COUNT(s_cnt), .OVF(s_ovf), .UDF(s_udf)
    );

    fifo_sync_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u_fw (
        .CLK(CLK), .RST(RST), .CLR(CLR), .W_EN(W_EN), .W_DI(W_DI), .REN(REN),
        .R_DO(f_rdo), .R_VALID(f_rv), .FULL(f_full), .EMPTY(f_empty),
        .AFULL(f_af), .AEMPTY(f_ae), .COUNT(f_cnt), .OVF(f_ovf), .UDF(f_udf)
    );

    always #5 CLK = ~CLK;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdo;
    logic             m_rv, m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdo = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step();
        int n;
        n = q.size();
        if (CLR) begin
            q.delete();
            m_rv  = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = W_EN && (n == DEPTH);
            m_udf = REN && (n == 0);
            if (REN && n != 0) begin
                m_rdo = q.pop_front();
                m_rv  = 1'b1;
            end else begin
                m_rv  = 1'b0;
            end
            if (W_EN && n != DEPTH) q.push_back(W_DI);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("std_count",  32'(s_cnt),   32'(n));
        check("std_empty",  32'(s_empty), 32'(n == 0));
        check("std_full",   32'(s_full),  32'(n == DEPTH));
        check("std_afull",  32'(s_af),    32'(n >= S_AF));
        check("std_aempty", 32'(s_ae),    32'(n <= S_AE));
        check("std_ovf",    32'(s_ovf),   32'(m_ovf));
        check("std_udf",    32'(s_udf),   32'(m_udf));
        check("std_rvalid", 32'(s_rv),    32'(m_rv));
        check("std_rdo",    32'(s_rdo),   32'(m_rdo));
        check("fw_count",   32'(f_cnt),   32'(n));
        check("fw_afull",   32'(f_af),    32'(n >= F_AF));
        check("fw_aempty",  32'(f_ae),    32'(n <= F_AE));
        check("fw_full",    32'(f_full),  32'(n == DEPTH));
        check("fw_ovf",     32'(f_ovf),   32'(m_ovf));
        check("fw_udf",     32'(f_udf),   32'(m_udf));
        check("fw_rvalid",  32'(f_rv),    32'(n != 0));
        check("fw_rdo",     32'(f_rdo),   (n != 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic cycle(input logic c, input logic w, input logic [WIDTH-1:0] d, input logic r);
        CLR  = c;
        W_EN = w;
        W_DI = d;
        REN  = r;
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        #1 check_all();

        // fill, overflow, drain
        cycle(0, 1, 8'h11, 0);
        cycle(0, 1, 8'h22, 0);
        cycle(0, 1, 8'h33, 0);
        cycle(0, 1, 8'h44, 0);
        cycle(0, 1, 8'h55, 0);
        cycle(0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0);

        // wrap-around at constant occupancy
        cycle(0, 1, 8'hE0, 0);
        cycle(0, 1, 8'hE1, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);

        // underflow with a simultaneous write, then read it back
        cycle(0, 1, 8'hA5, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0);

        // first-word-fall-through display and pop
        cycle(0, 1, 8'h7E, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 1);

        // thresholds walk, then flush with both requests active
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'hC0 + i), 0);
        cycle(1, 1, 8'hBB, 1);
        cycle(0, 0, 8'h00, 0);

        // flush while full with requests that would otherwise be errors
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'hD0 + i), 0);
        cycle(1, 1, 8'hBB, 0);
        cycle(0, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
                  ($urandom_range(0, 9) < 5));
        end

        // asynchronous reset in mid-cycle with the FIFO holding data
        cycle(0, 1, 8'h5A, 0);
        cycle(0, 1, 8'h5B, 1);
        #3 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #2 RST = 1'b0;
        check_all();
        cycle(0, 1, 8'h3C, 0);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised synchronous FIFO; the next generation of our FIFO family, generalised over depth, width and read mode. It adds a first-word-fall-through option, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and overflow/underflow error pulses. It sits between same-clock producer/consumer stages, for example UART RX and TX paths and DMA staging.

## Interface
- DEPTH, 16, number of entries; power of two, at least 2
- WIDTH, 8, data width in bits
- FWFT, 0, 0 = standard read (data one cycle after REN); 1 = first-word-fall-through
- AFULL_TH, DEPTH-2, AFULL asserted when COUNT >= AFULL_TH; legal range 1..DEPTH
- AEMPTY_TH, 2, AEMPTY asserted when COUNT <= AEMPTY_TH; legal range 0..DEPTH-1
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- CLR  in  1  synchronous flush; empties the FIFO and has priority over W_EN and REN
- W_EN  in  1  write request
- W_DI  in  WIDTH  write data
- REN  in  1  read request (standard mode) or pop (FWFT mode)
- R_DO  out  WIDTH  read data
- R_VALID  out  1  R_DO holds a valid word
- FULL / EMPTY  out  1  COUNT==DEPTH / COUNT==0
- AFULL / AEMPTY  out  1  threshold flags
- COUNT  out  $clog2(DEPTH)+1  number of stored entries
- OVF / UDF  out  1  one-cycle pulse: write while full / read while empty

## Operation
- Storage is a DEPTH x WIDTH array with write and read pointers of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. The array is not reset.
- Write acceptance: wr_ok = W_EN & !FULL & !CLR. The word is stored at wptr, then wptr increments.
- Read acceptance: rd_ok = REN & !EMPTY & !CLR. rptr increments.
- FULL and EMPTY are the values at the clock edge, computed from the registered COUNT.
- Write while FULL is dropped, even if a read is accepted in the same cycle. The next cycle shows OVF=1 and no change to storage.
- Read while EMPTY is ignored, even if a write is accepted in the same cycle. The next cycle shows UDF=1.
- COUNT next value: +1 for wr_ok only; -1 for rd_ok only; unchanged when both or neither occur.
- CLR: wptr, rptr and COUNT go to 0; R_VALID goes to 0; OVF and UDF go to 0; array contents are don't-care.
- Standard mode (FWFT=0):
  - On rd_ok, R_DO is registered with mem[rptr] and R_VALID pulses high for one cycle.
  - Otherwise R_DO holds its value and R_VALID goes to 0.
- FWFT mode (FWFT=1):
  - R_DO = mem[rptr] when !EMPTY, else 0.
  - R_VALID = !EMPTY.
  - REN consumes the displayed word; the next word, if any, appears in the following cycle.
- AFULL, AEMPTY, FULL and EMPTY are combinational decodes of the registered COUNT.

## Timing
- Reset values: COUNT=0, EMPTY=1, FULL=0, AFULL=0, AEMPTY=1, R_DO=0, R_VALID=0, OVF=0, UDF=0; pointers 0.
- Reset takes effect immediately on RST rising, with no clock required. It aborts any in-flight operation; no partial write is retained.
- Write to flag latency: 1 cycle. COUNT and EMPTY update on the edge that accepts the write.
- Standard-mode read latency: R_DO and R_VALID are valid 1 cycle after the REN edge.
- FWFT latency: a word written into an empty FIFO appears on R_DO and R_VALID 1 cycle after the write edge.
- Back-to-back reads and writes sustain 1 word per cycle in each direction.
- OVF and UDF are registered and assert the cycle after the offending request.

## Test plan
All scenarios use DEPTH=4, WIDTH=8.

- **Reset / idle.** Assert RST mid-cycle with no clock edge -> outputs reach reset values at once. After release: EMPTY=1, COUNT=0, AEMPTY=1.
- **Fill and overflow (FWFT=0).** Write 0x11, 0x22, 0x33, 0x44, then 0x55 -> COUNT goes 1..4, FULL=1 after the 4th write, OVF pulses once for 0x55. Read 4 times -> 0x11..0x44 in order, each one cycle after REN, with R_VALID pulses. 0x55 never appears.
- **Wrap-around with simultaneous read/write.** Keep the FIFO at COUNT=2 while writing 0x00..0x0F and reading each cycle -> COUNT stays at 2 and the output is in order across 4 pointer wraps.
- **Underflow (EMPTY case).** REN on an empty FIFO with simultaneous W_EN=0xA5 -> UDF pulses, COUNT=1, R_VALID=0. The next read returns 0xA5.
- **FWFT mode (FWFT=1).**
  - Write 0x7E into an empty FIFO -> next cycle R_DO=0x7E, R_VALID=1 without REN.
  - REN -> EMPTY=1 and R_DO=0 the following cycle.
- **Thresholds and CLR.** Use AFULL_TH=3, AEMPTY_TH=1.
  - At COUNT=1: AEMPTY=1. At COUNT=2: AEMPTY=0. At COUNT=3: AFULL=1.
  - CLR together with W_EN=1 and REN=1 -> COUNT=0, EMPTY=1, no OVF or UDF, write discarded.
